// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - KGP carry code type, constants and conversion helper
package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_KILL = 2'b00;
  localparam kgp_t KGP_GEN  = 2'b11;
  localparam kgp_t KGP_PROP = 2'b01;

  // Only G carries; either P encoding counts as no carry, same as K.
  function automatic logic kgp_to_carry(kgp_t k);
    return k == KGP_GEN;
  endfunction

endpackage

// File: rtl/kgp_pipe_adder_if.sv
// rtl/kgp_pipe_adder_if.sv - operand/result handshake bundle for kgp_pipe_adder
interface kgp_pipe_adder_if #(
  parameter int WIDTH = 32
);
  import kgp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  kgp_t             kIn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  kgp_t             kOut;
  logic             ovf;

  modport master (
    output in_valid, a, b, kIn, out_ready,
    input  in_ready, out_valid, sum, kOut, ovf
  );

  modport slave (
    input  in_valid, a, b, kIn, out_ready,
    output in_ready, out_valid, sum, kOut, ovf
  );

endinterface

// File: rtl/kgp_chunk_adder.sv
// rtl/kgp_chunk_adder.sv - combinational CHUNK-bit ripple adder with KGP carry codes
module kgp_chunk_adder
  import kgp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  kgp_t             cin,
  output logic [CHUNK-1:0] sum,
  output kgp_t             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    c[0] = kgp_to_carry(cin);
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum     = a ^ b ^ c[CHUNK-1:0];
  assign msb_cin = c[CHUNK-1];
  assign cout    = c[CHUNK] ? KGP_GEN : KGP_KILL;

endmodule

// File: rtl/kgp_pipe_adder.sv
// rtl/kgp_pipe_adder.sv - pipelined WIDTH-bit adder, CHUNK bits per stage, KGP carry in/out
module kgp_pipe_adder
  import kgp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             reset,
  kgp_pipe_adder_if.slave io
);

  localparam int NSTG    = WIDTH / CHUNK;
  localparam int SUMW    = CHUNK * NSTG * (NSTG + 1) / 2;
  localparam int OPW_RAW = CHUNK * NSTG * (NSTG - 1) / 2;
  localparam int OPW     = (OPW_RAW > 0) ? OPW_RAW : 1;

  // Stage g keeps its growing low sum (deskew) and the still-unsummed upper
  // operand bits (skew) packed back to back in shared flat vectors.
  function automatic int soff(int g);
    return CHUNK * g * (g + 1) / 2;
  endfunction

  function automatic int ooff(int g);
    return CHUNK * (g * (NSTG - 1) - g * (g - 1) / 2);
  endfunction

  logic            advance;
  logic [NSTG-1:0] v_q, v_d;
  logic [NSTG-1:0] c_q, c_d;
  logic [SUMW-1:0] s_q, s_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic            ovf_q, ovf_d;

  for (genvar g = 0; g < NSTG; g++) begin : g_stage
    localparam int OW = CHUNK * (NSTG - g);

    logic [OW-1:0]    op_a;
    logic [OW-1:0]    op_b;
    kgp_t             cin;
    kgp_t             cout;
    logic [CHUNK-1:0] csum;
    logic             msb_c;

    if (g == 0) begin : g_head
      assign op_a           = io.a;
      assign op_b           = io.b;
      assign cin            = io.kIn;
      assign v_d[0]         = io.in_valid;
      assign s_d[CHUNK-1:0] = csum;
    end else begin : g_body
      assign op_a   = a_q[ooff(g-1) +: OW];
      assign op_b   = b_q[ooff(g-1) +: OW];
      assign cin    = {2{c_q[g-1]}};
      assign v_d[g] = v_q[g-1];
      assign s_d[soff(g) +: (g+1)*CHUNK] = {csum, s_q[soff(g-1) +: g*CHUNK]};
    end

    kgp_chunk_adder #(
      .CHUNK(CHUNK)
    ) u_add (
      .a       (op_a[CHUNK-1:0]),
      .b       (op_b[CHUNK-1:0]),
      .cin     (cin),
      .sum     (csum),
      .cout    (cout),
      .msb_cin (msb_c)
    );

    assign c_d[g] = kgp_to_carry(cout);

    if (g < NSTG - 1) begin : g_fwd
      logic msb_unused;
      assign a_d[ooff(g) +: OW-CHUNK] = op_a[OW-1:CHUNK];
      assign b_d[ooff(g) +: OW-CHUNK] = op_b[OW-1:CHUNK];
      assign msb_unused               = msb_c;
    end else begin : g_tail
      // Signed overflow only makes sense at the word MSB, i.e. the last chunk.
      assign ovf_d = msb_c ^ c_d[g];
    end
  end

  assign advance = !v_q[NSTG-1] || io.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      c_q   <= '0;
      s_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q   <= v_d;
      c_q   <= c_d;
      s_q   <= s_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ovf_q <= ovf_d;
    end
  end

  assign io.in_ready  = advance;
  assign io.out_valid = v_q[NSTG-1];
  assign io.sum       = s_q[SUMW-1 -: WIDTH];
  assign io.kOut      = c_q[NSTG-1] ? KGP_GEN : KGP_KILL;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_kgp_pipe_adder.sv
// tb/tb_kgp_pipe_adder.sv - self-checking bench for kgp_pipe_adder (8-bit directed, 32-bit random)
module tb_kgp_pipe_adder;
  import kgp_pkg::*;

  typedef struct {
    logic [31:0] s;
    kgp_t        k;
    logic        o;
    int          acc;
    int          stalls;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kgp_pipe_adder_if #(.WIDTH(8))  if8 ();
  kgp_pipe_adder_if #(.WIDTH(32)) if32 ();

  kgp_pipe_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .io    (if8)
  );

  kgp_pipe_adder #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk   (clk),
    .reset (reset),
    .io    (if32)
  );

  task automatic run8(input logic [7:0] aa, input logic [7:0] bb, input kgp_t k,
                      output logic [7:0] s, output kgp_t ko, output logic o, output int lat);
    int c0;
    @(negedge clk);
    if8.in_valid  = 1'b1;
    if8.a         = aa;
    if8.b         = bb;
    if8.kIn       = k;
    if8.out_ready = 1'b1;
    c0  = cyc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if8.in_valid = 1'b0;
      #1;
      if (if8.out_valid === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    s  = if8.sum;
    ko = if8.kOut;
    o  = if8.ovf;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    if8.in_valid   = 1'b0;
    if8.out_ready  = 1'b0;
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b want 0", if8.out_valid); end
    checks++; if (if8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum8: got %h want 00", if8.sum); end
    checks++; if (if8.kOut !== KGP_KILL) begin errors++; $display("FAIL reset_kout8: got %b want 00", if8.kOut); end
    checks++; if (if8.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf8: got %b want 0", if8.ovf); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b want 1", if8.in_ready); end
    checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b want 0", if32.out_valid); end
    checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready32: got %b want 1", if32.in_ready); end
    if32.out_ready = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] s; kgp_t ko; logic o; int lat;
    run8(8'hDD, 8'hAA, KGP_KILL, s, ko, o, lat);
    checks++; if (s !== 8'h87) begin errors++; $display("FAIL basic_sum: got %h want 87", s); end
    checks++; if (ko !== KGP_GEN) begin errors++; $display("FAIL basic_kout: got %b want 11", ko); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", o); end
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
  endtask

  task automatic test_wrap();
    logic [7:0] s; kgp_t ko; logic o; int lat;
    run8(8'h7F, 8'h01, KGP_KILL, s, ko, o, lat);
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL wrap1_sum: got %h want 80", s); end
    checks++; if (ko !== KGP_KILL) begin errors++; $display("FAIL wrap1_kout: got %b want 00", ko); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL wrap1_ovf: got %b want 1", o); end
    run8(8'hFF, 8'h00, KGP_GEN, s, ko, o, lat);
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL wrap2_sum: got %h want 00", s); end
    checks++; if (ko !== KGP_GEN) begin errors++; $display("FAIL wrap2_kout: got %b want 11", ko); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL wrap2_ovf: got %b want 0", o); end
  endtask

  task automatic test_prop();
    logic [7:0] s; kgp_t ko; logic o; int lat;
    run8(8'h01, 8'h01, KGP_PROP, s, ko, o, lat);
    checks++; if (s !== 8'h02) begin errors++; $display("FAIL prop_sum: got %h want 02", s); end
    checks++; if (ko !== KGP_KILL) begin errors++; $display("FAIL prop_kout: got %b want 00", ko); end
    run8(8'h01, 8'h01, 2'b10, s, ko, o, lat);
    checks++; if (s !== 8'h02) begin errors++; $display("FAIL prop10_sum: got %h want 02", s); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ins [3];
    logic [7:0] want;
    int  sent = 0, got = 0, stall = 0;
    bit  seen = 0;
    ins[0] = 8'h01; ins[1] = 8'h02; ins[2] = 8'h03;
    for (int cy = 0; cy < 40 && got < 3; cy++) begin
      @(negedge clk);
      if8.in_valid  = (sent < 3);
      if8.a         = (sent < 3) ? ins[sent] : 8'h00;
      if8.b         = (sent < 3) ? ins[sent] : 8'h00;
      if8.kIn       = KGP_KILL;
      if8.out_ready = 1'b1;
      #1;
      if (if8.out_valid === 1'b1 && !seen) begin
        seen  = 1;
        stall = 3;
      end
      if (stall > 0) begin
        stall--;
        if8.out_ready = 1'b0;
        #1;
        want = ins[0] + ins[0];
        checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b want 0", if8.in_ready); end
        checks++; if (if8.sum !== want) begin errors++; $display("FAIL b2b_stall_sum: got %h want %h", if8.sum, want); end
      end
      if (if8.in_valid === 1'b1 && if8.in_ready === 1'b1) sent++;
      if (if8.out_valid === 1'b1 && if8.out_ready === 1'b1) begin
        want = (got < 3) ? ins[got] + ins[got] : 8'h00;
        checks++; if (if8.sum !== want) begin errors++; $display("FAIL b2b_order: got %h want %h", if8.sum, want); end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got); end
    if8.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: got out_valid %b want 0", if8.out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    if8.in_valid = 1'b1; if8.a = 8'h55; if8.b = 8'h22; if8.kIn = KGP_KILL; if8.out_ready = 1'b1;
    @(negedge clk);
    if8.a = 8'h11; if8.b = 8'h11;
    @(negedge clk);
    if8.in_valid = 1'b0; if8.out_ready = 1'b0;
    #1;
    checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got %b want 1", if8.out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; if8.out_ready = 1'b1;
    #1;
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", if8.out_valid); end
    checks++; if (if8.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h want 00", if8.sum); end
    checks++; if (if8.kOut !== KGP_KILL) begin errors++; $display("FAIL midrst_kout: got %b want 00", if8.kOut); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", if8.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: got out_valid %b want 0", if8.out_valid); end
    end
  endtask

  task automatic test_random32();
    exp_t        q[$];
    exp_t        e;
    int          accepted = 0, popped = 0, stalls = 0, lat;
    bit          head_seen = 0, prev_stall = 0, took = 0;
    logic [31:0] prev_sum;
    kgp_t        prev_k;
    logic        prev_o;
    logic [32:0] full;
    if32.in_valid = 1'b0;
    for (int cy = 0; cy < 20000 && popped < 1000; cy++) begin
      @(negedge clk);
      if (took) begin
        if32.in_valid = 1'b0;
        took = 0;
      end
      if (if32.in_valid !== 1'b1 && accepted < 1000 && $urandom_range(3) != 0) begin
        if32.in_valid = 1'b1;
        if32.a        = $urandom;
        if32.b        = $urandom;
        if32.kIn      = kgp_t'($urandom_range(3));
      end
      if32.out_ready = ($urandom_range(3) != 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (if32.out_valid !== 1'b1 || if32.sum !== prev_sum || if32.kOut !== prev_k || if32.ovf !== prev_o) begin
          errors++;
          $display("FAIL rnd_hold: got v=%b sum=%h k=%b o=%b want v=1 sum=%h k=%b o=%b",
                   if32.out_valid, if32.sum, if32.kOut, if32.ovf, prev_sum, prev_k, prev_o);
        end
      end
      if (if32.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_spurious: got out_valid 1 sum=%h want no output", if32.sum);
        end else begin
          if (!head_seen) begin
            head_seen = 1;
            lat = cyc - q[0].acc;
            checks++;
            if (q[0].stalls == stalls) begin
              if (lat != 8) begin errors++; $display("FAIL rnd_latency: got %0d want 8", lat); end
            end else if (lat < 8) begin
              errors++; $display("FAIL rnd_latency_min: got %0d want >=8", lat);
            end
          end
          if (if32.out_ready === 1'b1) begin
            checks++; if (if32.sum !== q[0].s) begin errors++; $display("FAIL rnd_sum: got %h want %h", if32.sum, q[0].s); end
            checks++; if (if32.kOut !== q[0].k) begin errors++; $display("FAIL rnd_kout: got %b want %b", if32.kOut, q[0].k); end
            checks++; if (if32.ovf !== q[0].o) begin errors++; $display("FAIL rnd_ovf: got %b want %b", if32.ovf, q[0].o); end
            void'(q.pop_front());
            popped++;
            head_seen = 0;
          end
        end
      end
      prev_stall = (if32.out_valid === 1'b1 && if32.out_ready !== 1'b1);
      if (prev_stall) begin
        stalls++;
        prev_sum = if32.sum;
        prev_k   = if32.kOut;
        prev_o   = if32.ovf;
      end
      if (if32.in_valid === 1'b1 && if32.in_ready === 1'b1) begin
        full     = {1'b0, if32.a} + {1'b0, if32.b} + ((if32.kIn == KGP_GEN) ? 33'd1 : 33'd0);
        e.s      = full[31:0];
        e.k      = full[32] ? KGP_GEN : KGP_KILL;
        e.o      = (if32.a[31] == if32.b[31]) && (full[31] != if32.a[31]);
        e.acc    = cyc;
        e.stalls = stalls;
        q.push_back(e);
        accepted++;
        took = 1;
      end
    end
    if32.in_valid = 1'b0;
    checks++;
    if (popped != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: got popped=%0d left=%0d want popped=1000 left=0", popped, q.size());
    end
  endtask

  initial begin
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.kIn  = KGP_KILL; if8.out_ready  = 1'b1;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.kIn = KGP_KILL; if32.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_prop();
    test_back_to_back();
    test_reset_midflight();
    test_random32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kgp_pipe_adder.md
Name: kgp_pipe_adder

Overview:
- Parametrised, pipelined successor to the 4-bit KGP-carry sum block; generalised in width.
- Adds two WIDTH-bit operands with a 2-bit kill/generate/propagate (KGP) carry-in code.
- Processes CHUNK bits per pipeline stage, with valid/ready handshake and back-pressure.
- Serves as the mantissa adder of the FloatAdd datapath; also returns the carry-out code and a signed-overflow flag.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits summed per pipeline stage.
NSTG, WIDTH/CHUNK, derived pipeline depth (localparam, not overridable).

Ports:
clk  in  1  single clock; all state on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operands and carry-in present this cycle.
in_ready  out  1  block accepts operands this cycle.
a  in  WIDTH  operand A (two's complement for overflow purposes).
b  in  WIDTH  operand B.
kIn  in  2  carry-in KGP code.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
sum  out  WIDTH  a+b+cin, modulo 2^WIDTH.
kOut  out  2  carry-out KGP code: K (2'b00) if no carry, G (2'b11) if carry.
ovf  out  1  signed overflow: carry into MSB differs from carry out of MSB.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- KGP encoding:
  - K = 2'b00 means carry 0.
  - G = 2'b11 means carry 1.
  - P = 2'b01 or 2'b10. P on kIn is sampled as carry 0, same as K.
  - kOut is only ever K or G.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
- Pipeline:
  - NSTG stages; stage i sums bits [i*CHUNK +: CHUNK] using the carry registered from stage i-1. Stage 0 uses kIn.
  - Upper operand bits are carried forward in skew registers; lower sum bits are carried forward in deskew registers.
  - All stage registers and per-stage valid bits shift only when advance=1. When advance=0, everything holds: no loss, no duplication.
- Latency: NSTG cycles from input transfer to out_valid, with no stall. Throughput: 1 per cycle.
- Bubbles: when in_valid=0 during advance, a bubble (valid=0) enters stage 0. Data registers may be left un-updated for bubbles.
- Reset:
  - All valid bits clear; out_valid=0.
  - sum=0, kOut=K, ovf=0.
  - in_ready=1 during the first cycle after reset.
  - Reset mid-operation discards all in-flight results; nothing emerges afterwards.
- Outputs are registered and stable while out_valid && !out_ready.
- Wrap-around:
  - sum is truncated to WIDTH; the carry is reported only via kOut.
  - ovf is computed from the MSB carries of the final stage.
- Simultaneous output pop and input push while the pipe is full is legal; full throughput is maintained.

Decomposition:
- Package kgp_pkg:
  - typedef logic[1:0] kgp_t.
  - Constants KGP_KILL=2'b00, KGP_GEN=2'b11, KGP_PROP=2'b01.
  - Function kgp_to_carry (G→1, else 0).
- Sub-module kgp_chunk_adder:
  - Combinational CHUNK-bit adder.
  - Inputs: a, b, kgp_t carry-in.
  - Outputs: sum, kgp_t carry-out, MSB carry-in (for ovf).
  - Instantiated NSTG times via generate.

Test Plan:
- WIDTH=8, CHUNK=4; a=8'hDD, b=8'hAA, kIn=K, out_ready=1 → after 2 cycles: sum=8'h87, kOut=G, ovf=0.
- a=8'h7F, b=8'h01, kIn=K → sum=8'h80, kOut=K, ovf=1. Then a=8'hFF, b=8'h00, kIn=G → sum=8'h00, kOut=G, ovf=0.
- kIn=2'b01 (P) with a=8'h01, b=8'h01 → sum=8'h02, kOut=K (P treated as carry 0).
- Back-to-back operands 8'h01+8'h01, 8'h02+8'h02, 8'h03+8'h03; hold out_ready=0 for 3 cycles after the first out_valid → in_ready=0 while stalled, sum stays 8'h02, then 8'h02/8'h04/8'h06 emerge in order, with no loss or duplication.
- Assert reset while two results are in flight → next cycle out_valid=0, sum=0, kOut=K, in_ready=1; no stale result appears in the following 4 cycles.
- WIDTH=32, CHUNK=4, random 1000 vectors with random in_valid/out_ready → scoreboard matches {carry,sum}=a+b+cin and the ovf reference model; latency is exactly 8 when unstalled.
